// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit half of the UART link. Bytes enter through a small FIFO and are
//   serialised as start + DATA_BITS (LSB first) + STOP_BITS stop bits. Bit timing
//   comes from clkEn, the same OVERSAMPLE-rate tick that drives the receiver.
//   Frames run back-to-back while the FIFO holds data; the line idles high.
//
// Ports
//   clk        system clock, all logic on posedge
//   rstN       asynchronous active-low reset
//   clkEn      baud x OVERSAMPLE tick, one clk wide
//   inData     byte to transmit, sampled only when it is pushed
//   inValid    inData valid
//   inReady    FIFO can accept (not full)
//   serialData UART line, registered, idle high
//   busy       frame in progress or FIFO non-empty
//   fifoCount  entries currently held in the FIFO
//   dbgState   current FSM state (0 idle, 1 start, 2 data, 3 stop)
//
// Handshake: a byte is transferred on every clk edge where inValid && inReady,
// regardless of clkEn. inReady depends only on the registered count, so a pop in
// the same cycle never lets a push into a full FIFO. inData/inValid may change
// freely while inReady is low.

module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          clkEn,
  input  logic [DATA_BITS-1:0]          inData,
  input  logic                          inValid,
  output logic                          inReady,
  output logic                          serialData,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [1:0]                    dbgState
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
  localparam int TW         = $clog2(STOP_TICKS + 1);
  localparam int BW         = $clog2(DATA_BITS);

  localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COUNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE      = AW'(1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST    = TW'(STOP_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE     = TW'(1);
  localparam logic [BW-1:0] BIT_CNT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE      = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [TW-1:0]        tickCnt;
  logic [BW-1:0]        bitCnt;
  logic [DATA_BITS-1:0] shiftReg;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr;
  logic [AW-1:0]        rdPtr;
  logic                 pushEn;
  logic                 popEn;

  assign inReady  = (fifoCount != FULL_COUNT);
  assign pushEn   = inValid && inReady;
  // A pop happens only on a tick where the FSM is ready for a new frame: from
  // idle, or on the last stop tick so the next start bit follows with no gap.
  assign popEn    = clkEn && (fifoCount != '0) &&
                    ((state == S_IDLE) || ((state == S_STOP) && (tickCnt == STOP_LAST)));
  assign busy     = (state != S_IDLE) || (fifoCount != '0);
  assign dbgState = state;

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= inData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PTR_ONE;
      if (popEn)  rdPtr <= rdPtr + PTR_ONE;
      case ({pushEn, popEn})
        2'b10:   fifoCount <= fifoCount + COUNT_ONE;
        2'b01:   fifoCount <= fifoCount - COUNT_ONE;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= S_IDLE;
      serialData <= 1'b1;
      tickCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
    end else if (clkEn) begin
      case (state)
        S_IDLE: begin
          serialData <= 1'b1;
          if (popEn) begin
            shiftReg   <= mem[rdPtr];
            serialData <= 1'b0;
            tickCnt    <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (tickCnt == BIT_LAST) begin
            serialData <= shiftReg[0];
            bitCnt     <= '0;
            tickCnt    <= '0;
            state      <= S_DATA;
          end else begin
            tickCnt <= tickCnt + TICK_ONE;
          end
        end
        S_DATA: begin
          if (tickCnt == BIT_LAST) begin
            tickCnt  <= '0;
            shiftReg <= shiftReg >> 1;
            if (bitCnt == BIT_CNT_LAST) begin
              serialData <= 1'b1;
              state      <= S_STOP;
            end else begin
              // shiftReg[1] is the bit that lands in [0] after this shift.
              serialData <= shiftReg[1];
              bitCnt     <= bitCnt + BIT_ONE;
            end
          end else begin
            tickCnt <= tickCnt + TICK_ONE;
          end
        end
        S_STOP: begin
          if (tickCnt == STOP_LAST) begin
            tickCnt <= '0;
            if (popEn) begin
              shiftReg   <= mem[rdPtr];
              serialData <= 1'b0;
              state      <= S_START;
            end else begin
              serialData <= 1'b1;
              state      <= S_IDLE;
            end
          end else begin
            tickCnt <= tickCnt + TICK_ONE;
          end
        end
        default: begin
          state      <= S_IDLE;
          serialData <= 1'b1;
          tickCnt    <= '0;
          bitCnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A 1-stop-bit instance carries most tests;
//   a 2-stop-bit instance checks stop length and back-to-back frames. A tick-domain
//   receiver model decodes the line into rxQ and an edge logger records the cycle
//   of every line transition.

module tb_uart_tx_fifo;

  localparam int OS = 16;

  // ---------------- clock / reset / signals ----------------
  logic       clk;
  logic       rstN;
  logic       clkEn;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic       serialData;
  logic       busy;
  logic [2:0] fifoCount;
  logic [1:0] dbgState;

  logic [7:0] inData2;
  logic       inValid2;
  logic       inReady2;
  logic       serialData2;
  logic       busy2;
  logic [2:0] fifoCount2;
  logic [1:0] dbgState2;

  uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rstN(rstN), .clkEn(clkEn), .inData(inData), .inValid(inValid),
    .inReady(inReady), .serialData(serialData), .busy(busy), .fifoCount(fifoCount),
    .dbgState(dbgState)
  );

  uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rstN(rstN), .clkEn(clkEn), .inData(inData2), .inValid(inValid2),
    .inReady(inReady2), .serialData(serialData2), .busy(busy2), .fifoCount(fifoCount2),
    .dbgState(dbgState2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clkEn pattern: 0 = off, 1 = every cycle, 3 = every third cycle
  int enPeriod = 0;
  int enPhase  = 0;
  initial begin
    clkEn = 1'b0;
    forever begin
      @(negedge clk);
      enPhase = (enPhase + 1) % 3;
      clkEn = (enPeriod == 1) || ((enPeriod == 3) && (enPhase == 0));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         nChecks = 0;
  int         nPass   = 0;
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  int         edgeQ[$];
  int         edge2Q[$];
  int         frameStartQ[$];
  int         cyc = 0;
  int         tick = 0;
  int         badEdges = 0;
  int         stopErrs = 0;
  logic       line1Prev = 1'b1;
  logic       line2Prev = 1'b1;
  logic       rxActive = 1'b0;
  int         rxCnt = 0;
  logic [7:0] rxSh = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Receiver model: one call per clkEn tick with the line value for that tick.
  // Samples mid-bit, relative to the first low tick of the start bit.
  task automatic rxStep(input logic b);
    if (!rxActive) begin
      if (b == 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 0;
        frameStartQ.push_back(tick);
      end
    end else begin
      rxCnt++;
      if (rxCnt > OS && rxCnt < 9*OS && (rxCnt % OS) == OS/2) begin
        rxSh[rxCnt/OS - 1] = b;
      end else if (rxCnt == 9*OS + OS/2) begin
        if (b !== 1'b1) stopErrs++;
        rxQ.push_back(rxSh);
        rxActive = 1'b0;
      end
    end
  endtask

  // Monitor: counts cycles/ticks at the edge, samples outputs 1 time unit later.
  initial begin : monitorProc
    logic enAtEdge;
    forever begin
      @(posedge clk);
      cyc++;
      enAtEdge = clkEn;
      if (clkEn) tick++;
      #1;
      if (!rstN) rxActive = 1'b0;
      else if (enAtEdge) rxStep(serialData);
      if (serialData !== line1Prev) begin
        edgeQ.push_back(cyc);
        if (!enAtEdge) badEdges++;
        line1Prev = serialData;
      end
      if (serialData2 !== line2Prev) begin
        edge2Q.push_back(cyc);
        line2Prev = serialData2;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pushByte(input logic [7:0] b, output logic accepted, output int pushCyc);
    @(negedge clk);
    inData   = b;
    inValid  = 1'b1;
    accepted = inReady;
    @(posedge clk);
    #1;
    pushCyc = cyc;
    inValid = 1'b0;
    if (accepted) expQ.push_back(b);
  endtask

  task automatic pushByte2(input logic [7:0] b);
    @(negedge clk);
    inData2  = b;
    inValid2 = 1'b1;
    @(posedge clk);
    #1;
    inValid2 = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input bit useDut2, output int idleCyc,
                          output int idleTick, output logic timedOut);
    int n;
    n = 0;
    timedOut = 1'b1;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (!(useDut2 ? busy2 : busy)) begin
        timedOut = 1'b0;
        break;
      end
    end
    idleCyc  = cyc;
    idleTick = tick;
  endtask

  task automatic scoreboard(input string tag);
    check({tag, "_count"}, rxQ.size(), expQ.size());
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      check(tag, 32'(rxQ.pop_front()), 32'(expQ.pop_front()));
    end
    rxQ.delete();
    expQ.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic acc;
    logic to;
    logic found;
    logic prevRdy;
    logic sawLow;
    int   pc, ic, it, e0, base, s0, n, budget, rises;

    rstN = 1'b0;
    inValid = 1'b0; inData = '0;
    inValid2 = 1'b0; inData2 = '0;
    repeat (3) @(negedge clk);

    check("rst_line",  32'(serialData), 1);
    check("rst_ready", 32'(inReady), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_count", 32'(fifoCount), 0);
    @(negedge clk);
    rstN = 1'b1;

    // single 0xA5 frame, clkEn every cycle
    enPeriod = 1;
    repeat (2) @(negedge clk);
    base = edgeQ.size();
    pushByte(8'hA5, acc, pc);
    check("a5_accept", 32'(acc), 1);
    check("a5_busy_after_push", 32'(busy), 1);
    waitIdle(400, 1'b0, ic, it, to);
    check("a5_timeout", 32'(to), 0);
    check("a5_edges", edgeQ.size() - base, 8);
    if (edgeQ.size() >= base + 8) begin
      e0 = edgeQ[base];
      check("a5_latency",   e0 - pc, 1);
      check("a5_bit5_rise", edgeQ[base+5] - e0, 96);
      check("a5_bit7_rise", edgeQ[base+7] - e0, 128);
      check("a5_busy_len",  ic - e0, 160);
    end
    scoreboard("a5_rx");

    // fill FIFO with clkEn off, overflow push dropped, then four contiguous frames
    enPeriod = 0;
    repeat (2) @(negedge clk);
    base = edgeQ.size();
    s0   = frameStartQ.size();
    for (int k = 1; k <= 4; k++) pushByte(8'(k), acc, pc);
    check("full_count", 32'(fifoCount), 4);
    check("full_ready", 32'(inReady), 0);
    pushByte(8'hFF, acc, pc);
    check("full_drop", 32'(acc), 0);
    check("full_count_after_drop", 32'(fifoCount), 4);
    check("full_line_frozen", edgeQ.size() - base, 0);
    enPeriod = 1;
    waitIdle(1000, 1'b0, ic, it, to);
    check("burst_timeout", 32'(to), 0);
    check("burst_frames", frameStartQ.size() - s0, 4);
    if (frameStartQ.size() >= s0 + 4) begin
      for (int k = 1; k < 4; k++) begin
        check("burst_gap", frameStartQ[s0+k] - frameStartQ[s0+k-1], 160);
      end
      check("burst_ticks", it - frameStartQ[s0], 640);
    end
    scoreboard("burst_rx");

    // clkEn every third clk, 0x3C: 48 clk per bit
    enPeriod = 3;
    repeat (3) @(negedge clk);
    base = edgeQ.size();
    badEdges = 0;
    pushByte(8'h3C, acc, pc);
    waitIdle(1500, 1'b0, ic, it, to);
    check("div3_timeout", 32'(to), 0);
    check("div3_edges", edgeQ.size() - base, 4);
    if (edgeQ.size() >= base + 4) begin
      e0 = edgeQ[base];
      check("div3_rise1", edgeQ[base+1] - e0, 144);
      check("div3_fall2", edgeQ[base+2] - e0, 336);
      check("div3_stop",  edgeQ[base+3] - e0, 432);
    end
    check("div3_bad_edges", badEdges, 0);
    scoreboard("div3_rx");

    // push every cycle while frames run
    enPeriod = 1;
    repeat (2) @(negedge clk);
    n = 0; budget = 0; rises = 0;
    prevRdy = 1'b1; sawLow = 1'b0;
    while (n < 20 && budget < 5000) begin
      @(negedge clk);
      inData  = 8'($urandom_range(0, 255));
      inValid = 1'b1;
      if (!inReady) sawLow = 1'b1;
      if (inReady && !prevRdy) rises++;
      prevRdy = inReady;
      if (inReady) begin
        expQ.push_back(inData);
        n++;
      end
      budget++;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    check("stream_accepted", n, 20);
    check("stream_saw_full", 32'(sawLow), 1);
    check("stream_ready_rises", rises, 15);
    waitIdle(2000, 1'b0, ic, it, to);
    check("stream_timeout", 32'(to), 0);
    scoreboard("stream_rx");

    // two stop bits: 0x00 then 0xFF back to back
    enPeriod = 0;
    repeat (2) @(negedge clk);
    base = edge2Q.size();
    pushByte2(8'h00);
    pushByte2(8'hFF);
    check("stop2_count", 32'(fifoCount2), 2);
    enPeriod = 1;
    waitIdle(800, 1'b1, ic, it, to);
    check("stop2_timeout", 32'(to), 0);
    check("stop2_edges", edge2Q.size() - base, 4);
    if (edge2Q.size() >= base + 4) begin
      e0 = edge2Q[base];
      check("stop2_data_low",     edge2Q[base+1] - e0, 144);
      check("stop2_stop_len",     edge2Q[base+2] - edge2Q[base+1], 32);
      check("stop2_frame_len",    edge2Q[base+2] - e0, 176);
      check("stop2_second_start", edge2Q[base+3] - edge2Q[base+2], 16);
      check("stop2_second_len",   ic - edge2Q[base+2], 176);
    end
    check("stop2_line_idle", 32'(serialData2), 1);

    // reset at tick 70 of a 0x55 frame with two bytes queued
    enPeriod = 1;
    repeat (2) @(negedge clk);
    s0 = frameStartQ.size();
    pushByte(8'h55, acc, pc);
    pushByte(8'h11, acc, pc);
    pushByte(8'h22, acc, pc);
    n = 0; found = 1'b0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (frameStartQ.size() > s0 && tick - frameStartQ[s0] >= 70) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_found", 32'(found), 1);
    check("rst_mid_line_before", 32'(serialData), 0);
    check("rst_mid_count_before", 32'(fifoCount), 2);
    rstN = 1'b0;
    #1;
    check("rst_mid_line",  32'(serialData), 1);
    check("rst_mid_count", 32'(fifoCount), 0);
    check("rst_mid_busy",  32'(busy), 0);
    check("rst_mid_ready", 32'(inReady), 1);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    base = edgeQ.size();
    repeat (300) @(negedge clk);
    check("rst_after_edges", edgeQ.size() - base, 0);
    check("rst_after_line",  32'(serialData), 1);
    check("rst_after_busy",  32'(busy), 0);
    check("rst_after_rx",    rxQ.size(), 0);
    expQ.delete();
    rxQ.delete();

    check("rx_stop_bits", stopErrs, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
